// File: rtl/div_iter_unit_pkg.sv
// Shared divider types and constants: operation encoding, FSM states and
// the fixed results of the RV32M special cases.
package div_iter_unit_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } div_state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/div_iter_unit_clz.sv
// Count-leading-zeros on a 32-bit word; an all-zero input returns 32.
module div_iter_unit_clz (
  input  logic [31:0] i_data,
  output logic [5:0]  o_count
);

  // NOTE: every always_comb output gets a default before any branch, so no path infers a latch.
  always_comb begin
    o_count = 6'd32;
    // Ascending scan: the highest set bit is the last one to write o_count.
    for (int i = 0; i < 32; i++) begin
      if (i_data[i]) o_count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): CLZ-normalised restoring
// division that runs only as many iterations as the dividend has significant bits.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e      r_state, w_next_state;
  logic [XLEN-1:0] r_shift, r_prem, r_divisor, r_result;
  logic [CNTW-1:0] r_count;
  logic            r_qneg, r_rneg, r_sel_rem;

  logic            w_signed, w_accept;
  logic            w_div_zero, w_overflow, w_small, w_special;
  logic [XLEN-1:0] w_a, w_b;
  logic [XLEN-1:0] w_spec_q, w_spec_r, w_spec_result;
  logic [XLEN-1:0] w_quo, w_rem;
  logic [5:0]      w_z;
  logic [CNTW-1:0] w_n;
  logic [XLEN:0]   w_trial;
  logic            w_qbit;

  // Operand decode: DIV and REM (op[0]==0) are the signed flavours.
  assign w_signed   = ~op[0];
  assign w_a        = (w_signed && rs1[XLEN-1]) ? -rs1 : rs1;
  assign w_b        = (w_signed && rs2[XLEN-1]) ? -rs2 : rs2;
  assign w_div_zero = (rs2 == '0);
  assign w_overflow = w_signed && (rs1 == INT_MIN) && (rs2 == '1);
  assign w_small    = (w_a < w_b);
  assign w_special  = w_div_zero || w_overflow || w_small;
  assign w_accept   = start && !kill && (r_state == IDLE || r_state == DONE);

  always_comb begin
    w_spec_q = '0;
    w_spec_r = rs1;
    if (w_div_zero) begin
      w_spec_q = DIV_ZERO_Q;
    end else if (w_overflow) begin
      w_spec_q = INT_MIN;
      w_spec_r = '0;
    end
  end

  assign w_spec_result = op[1] ? w_spec_r : w_spec_q;

  div_iter_unit_clz u_clz (
    .i_data  (w_a),
    .o_count (w_z)
  );

  assign w_n = CNTW'(XLEN) - CNTW'(w_z);

  // 33-bit trial subtraction; bit XLEN set means the divisor did not fit.
  assign w_trial = {r_prem, r_shift[XLEN-1]} - {1'b0, r_divisor};
  assign w_qbit  = ~w_trial[XLEN];

  assign w_quo = r_qneg ? -r_shift : r_shift;
  assign w_rem = r_rneg ? -r_prem : r_prem;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (kill) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start)      w_next_state = w_special ? DONE : CALC;
          else            w_next_state = IDLE;
        end
        CALC:    if (r_count == CNTW'(1)) w_next_state = SIGN;
        SIGN:    w_next_state = DONE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      CALC, SIGN: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_prem    <= '0;
      r_divisor <= '0;
      r_count   <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_sel_rem <= 1'b0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_sel_rem <= op[1];
      if (w_special) begin
        r_result <= w_spec_result;
        r_qneg   <= 1'b0;
        r_rneg   <= 1'b0;
      end else begin
        // Left-justify the dividend so only its N significant bits are iterated.
        r_shift   <= w_a << w_z;
        r_prem    <= '0;
        r_divisor <= w_b;
        r_count   <= w_n;
        r_qneg    <= (op == DIV) && (rs1[XLEN-1] ^ rs2[XLEN-1]);
        r_rneg    <= (op == REM) && rs1[XLEN-1];
      end
    end else if (r_state == CALC) begin
      r_prem  <= w_qbit ? w_trial[XLEN-1:0] : {r_prem[XLEN-2:0], r_shift[XLEN-1]};
      r_shift <= {r_shift[XLEN-2:0], w_qbit};
      r_count <= r_count - CNTW'(1);
    end else if (r_state == SIGN && !kill) begin
      r_result <= r_sel_rem ? w_rem : w_quo;
    end
  end

  assign result = r_result;

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Multi-cycle RV32M divider for DIV/DIVU/REM/REMU, sitting in the EX stage beside the ALU.
- Normalises the dividend's magnitude with a CLZ instance, then runs only 32-clz restoring iterations (one quotient bit per cycle). Small dividends therefore finish early.
- Returns a single-cycle done pulse with the selected quotient or remainder; the pipeline stalls on busy.

Parameters:
- XLEN, 32, operand/result width (matches `RegBus).
- CNTW, 6, iteration counter width (matches `RegNumLog2+1; holds 0..32).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when state is IDLE or DONE.
- kill  input  1  pipeline flush; abandons any operation in flight.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1  input  XLEN  dividend.
- rs2  input  XLEN  divisor.
- busy  output  1  high in CALC and SIGN.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU); held until the next accepted start.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0.
  - All internal registers (dividend shifter, partial remainder, divisor, counter, sign flags) cleared.
  - Reset mid-operation discards the operation; no done is produced.
- States: IDLE, CALC, SIGN, DONE.
- Accept, start=1 in IDLE/DONE with kill=0, call this cycle k:
  - Signed ops: magnitudes a=|rs1|, b=|rs2|. qneg=rs1[31]^rs2[31] (DIV only). rneg=rs1[31] (REM only). Unsigned ops: a=rs1, b=rs2, no sign flags.
  - Special cases go straight to DONE; done is high in cycle k+1:
    - rs2==0: quotient=32'hFFFF_FFFF, remainder=rs1.
    - Signed op with rs1=32'h8000_0000 and rs2=32'hFFFF_FFFF: quotient=32'h8000_0000, remainder=0.
    - a<b unsigned (this includes a==0): quotient=0, remainder=rs1 unmodified.
  - Otherwise:
    - z=CLZ(a), N=32-z (range 1..32).
    - Load shifter=a<<z, partial remainder=0, divisor=b, counter=N; go to CALC.
- CALC, one iteration per cycle:
  - trial=(prem<<1 | shifter[31]) - b, computed 33 bits wide.
  - If trial is non-negative: prem=trial[31:0] and quotient bit=1; else prem keeps the shifted value and quotient bit=0.
  - Shifter shifts left, inserting the quotient bit at bit 0. counter decrements.
  - When counter==1 in CALC, next state is SIGN. CALC lasts exactly N cycles.
- SIGN (one cycle):
  - Negate the quotient if qneg; negate the remainder if rneg.
  - Register result from op[1] (0 selects quotient, 1 selects remainder); go to DONE.
- DONE: done=1, busy=0, for exactly one cycle.
  - start in DONE is accepted, giving back-to-back operations.
  - Otherwise go to IDLE.
- Latency: the normal path asserts done in cycle k+N+2. The best normal case is 3 cycles (N=1); the worst is 34 cycles (N=32).
- start while busy is ignored; the issuing stage must hold it.
- kill in any state:
  - Next state is IDLE, and done is not asserted in the following cycle.
  - kill has priority over start in the same cycle.
  - result is not updated.
- Arithmetic:
  - Magnitude of 32'h8000_0000 is 32'h8000_0000, taken as unsigned.
  - All comparisons are unsigned on magnitudes.
  - Sign fixes use two's complement, mod 2^32.

Decomposition:
- Shared CPU package:
  - typedef enum div_op_e {DIV, DIVU, REM, REMU} (2 bits).
  - typedef enum div_state_e {IDLE, CALC, SIGN, DONE}.
  - Constants DIV_ZERO_Q=32'hFFFF_FFFF and INT_MIN=32'h8000_0000.
- One sub-module: the existing CLZ, instantiated on the magnitude a, with its 6-bit result used directly as z.
- Iteration datapath and FSM stay in div_iter_unit.

Test Plan:
- DIVU rs1=100, rs2=7, start at cycle k:
  - Expected z=25, N=7; busy high k+1..k+8; done at k+9 with result=14.
  - REMU with the same operands gives result=2.
- DIV rs1=-100 (32'hFFFF_FF9C), rs2=7 -> result=32'hFFFF_FFF2 (-14). REM with the same operands -> 32'hFFFF_FFFE (-2).
- Special cases:
  - DIVU with rs2=0 -> done at k+1, result=32'hFFFF_FFFF.
  - REM rs1=32'h8000_0000, rs2=32'hFFFF_FFFF -> done at k+1, result=0.
  - DIV with the same operands -> result=32'h8000_0000.
- DIVU rs1=32'hFFFF_FFFF, rs2=1 -> N=32; done at k+34, result=32'hFFFF_FFFF. DIVU rs1=3, rs2=5 -> done at k+1, result=0.
- Back-to-back: start held high across the DONE cycle with new operands DIVU 9/3 -> two done pulses, results 14 then 3, no idle cycle between the accepts.
- Aborts:
  - kill asserted at k+3 of a 34-cycle divide -> state is IDLE at k+4, no done pulse, result unchanged.
  - rst_n pulsed low mid-CALC -> busy=0 and result=0 immediately (asynchronously).
